pakout: RTL and testbench
=========================

Name: pakout

Overview:
- Transmit-side counterpart of pakin.
- Accepts one full packet (PSZ bits) on a four-phase receive channel and serialises it into NUM_CHK chunks of CSZ bits on a four-phase pakio send channel.
- Each chunk carries a "last" flag, so a downstream pakin can rebuild the packet.
- Sits between a packet producer (cell or pakin_io source side) and a narrow inter-node link.

Parameters:
- PSZ, `NS_PACKET_SIZE, packet width in bits.
- CSZ, `NS_DATA_SIZE, chunk width in bits; CSZ <= PSZ.
- NUM_CHK, (PSZ+CSZ-1)/CSZ, derived and not overridable; chunks per packet.
- CNT_WDH, 8, width of the sent-packet counter.

Ports:
- gch_clk  input  1  single clock; all logic is on its rising edge.
- gch_reset  input  1  synchronous, active-high reset.
- gch_ready  output  1  block initialised and able to accept packets.
- rcv0_req  input  1  upstream packet request (four-phase).
- rcv0_data  input  PSZ  upstream packet; stable while rcv0_req=1.
- rcv0_ack  output  1  upstream acknowledge.
- snd0_req  output  1  chunk request (four-phase).
- snd0_data  output  CSZ  chunk payload.
- snd0_last  output  1  marks the final chunk of a packet.
- snd0_ack  input  1  downstream acknowledge.
- dbg_pkt_cnt  output  CNT_WDH  count of fully sent packets.

Behaviour:
- Reset: gch_ready=0, rcv0_ack=0, snd0_req=0, snd0_data=0, snd0_last=0, dbg_pkt_cnt=0, chunk index=0, state=IDLE. All take effect on the first clock edge with gch_reset=1.
- Reset mid-operation: the packet in progress is discarded, both req/ack outputs drop to 0, and no partial "last" is ever emitted.
- gch_ready rises on the first edge after gch_reset is seen low, and stays 1 until the next reset.
- Four-phase rule, both channels: req up -> ack up -> req down -> ack down. Data is valid from req rise until ack rise.
- State IDLE: if gch_ready=1 and rcv0_req=1, latch rcv0_data into shift register pk, set rcv0_ack=1, go to RCV_REL. The ack appears 1 cycle after req is sampled high.
- State RCV_REL: wait for rcv0_req=0, then set rcv0_ack=0, idx=0, go to SND_REQ. The upstream handshake is fully closed before any chunk leaves.
- State SND_REQ:
  - drive snd0_data = pk[PSZ-1 -: CSZ] (MSB chunk first);
  - drive snd0_last = (idx==NUM_CHK-1);
  - set snd0_req=1; go to SND_ACK.
  - Data and last are registered in the same cycle as req.
- State SND_ACK: wait for snd0_ack=1, then set snd0_req=0, go to SND_REL. snd0_data is held until snd0_ack rises.
- State SND_REL: wait for snd0_ack=0.
  - If idx==NUM_CHK-1: dbg_pkt_cnt += 1 (wraps modulo 2^CNT_WDH), snd0_last=0, go to IDLE.
  - Else: pk shifts left by CSZ, idx += 1, go to SND_REQ.
- Padding: if PSZ is not a multiple of CSZ, the final chunk carries the remaining PSZ mod CSZ packet bits in its MSBs, zero-padded in its LSBs.
- Minimum cost per chunk is 3 cycles plus downstream latency. A new packet is accepted only in IDLE; rcv0_req held high while busy is simply not acknowledged.
- Protocol violations:
  - snd0_ack=1 while in SND_REQ or IDLE is ignored.
  - rcv0_req dropping before rcv0_ack rises cannot happen (the ack rises in the same edge that samples req).
- NUM_CHK==1 (CSZ==PSZ): a single chunk with snd0_last=1.

Test Plan:
- Reset then idle: hold gch_reset=1 for 3 cycles, release -> gch_ready=1 after exactly 1 edge; all other outputs 0; no req without input.
- Basic serialisation, PSZ=32, CSZ=8: send 0xA1B2C3D4 with an immediate-ack responder -> chunks 0xA1, 0xB2, 0xC3, 0xD4 in order; snd0_last=1 only on 0xD4; dbg_pkt_cnt=1.
- Padding, PSZ=20, CSZ=8: send 20'hABCDE -> chunks 0xAB, 0xCD, 0xE0; last on 0xE0.
- Backpressure: responder delays snd0_ack by 7 cycles per chunk -> snd0_data stable throughout each wait; no chunk skipped or duplicated; a second upstream packet held pending gets rcv0_ack only after the first packet's final ack falls.
- Mid-packet reset: assert gch_reset after chunk 2 of 4 is acked -> next edge snd0_req=0, rcv0_ack=0, dbg_pkt_cnt=0; a following packet 0x01020304 is sent completely from chunk 0x01.
- Counter wrap, CNT_WDH=8: send 256 packets -> dbg_pkt_cnt returns to 0; the 257th packet gives 1.

Source files
------------

// File: rtl/pakout.sv
`default_nettype none
// ============================================================================
// Module   : pakout
// Brief    : Packet-to-chunk serialiser. Takes one PSZ-bit packet on a
//            four-phase receive channel and emits it MSB-first as NUM_CHK
//            CSZ-bit chunks, with a last flag, on a four-phase send channel.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 32
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif

module pakout #(
    parameter int PSZ     = `NS_PACKET_SIZE,
    parameter int CSZ     = `NS_DATA_SIZE,
    parameter int CNT_WDH = 8
) (
    input  logic               gch_clk,
    input  logic               gch_reset,
    output logic               gch_ready,
    input  logic               rcv0_req,
    input  logic [PSZ-1:0]     rcv0_data,
    output logic               rcv0_ack,
    output logic               snd0_req,
    output logic [CSZ-1:0]     snd0_data,
    output logic               snd0_last,
    input  logic               snd0_ack,
    output logic [CNT_WDH-1:0] dbg_pkt_cnt
);

    localparam int NUM_CHK = (PSZ + CSZ - 1) / CSZ;
    localparam int IDX_W   = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_CHK - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RCV_REL = 3'd1,
        S_SND_REQ = 3'd2,
        S_SND_ACK = 3'd3,
        S_SND_REL = 3'd4
    } state_t;

    state_t             r_state_q,  w_state_d;
    logic [PSZ-1:0]     r_pk_q,     w_pk_d;
    logic [IDX_W-1:0]   r_idx_q,    w_idx_d;
    logic               r_ready_q,  w_ready_d;
    logic               r_rack_q,   w_rack_d;
    logic               r_sreq_q,   w_sreq_d;
    logic [CSZ-1:0]     r_sdata_q,  w_sdata_d;
    logic               r_slast_q,  w_slast_d;
    logic [CNT_WDH-1:0] r_cnt_q,    w_cnt_d;

    always_comb begin
        w_state_d = r_state_q;
        w_pk_d    = r_pk_q;
        w_idx_d   = r_idx_q;
        w_ready_d = 1'b1;
        w_rack_d  = r_rack_q;
        w_sreq_d  = r_sreq_q;
        w_sdata_d = r_sdata_q;
        w_slast_d = r_slast_q;
        w_cnt_d   = r_cnt_q;

        case (r_state_q)
            S_IDLE: begin
                if (r_ready_q && rcv0_req) begin
                    w_pk_d    = rcv0_data;
                    w_rack_d  = 1'b1;
                    w_state_d = S_RCV_REL;
                end
            end
            // Upstream handshake closes completely before the first chunk.
            S_RCV_REL: begin
                if (!rcv0_req) begin
                    w_rack_d  = 1'b0;
                    w_idx_d   = '0;
                    w_state_d = S_SND_REQ;
                end
            end
            S_SND_REQ: begin
                w_sdata_d = r_pk_q[PSZ-1 -: CSZ];
                w_slast_d = (r_idx_q == C_LAST_IDX);
                w_sreq_d  = 1'b1;
                w_state_d = S_SND_ACK;
            end
            S_SND_ACK: begin
                if (snd0_ack) begin
                    w_sreq_d  = 1'b0;
                    w_state_d = S_SND_REL;
                end
            end
            S_SND_REL: begin
                if (!snd0_ack) begin
                    if (r_idx_q == C_LAST_IDX) begin
                        w_cnt_d   = r_cnt_q + CNT_WDH'(1);
                        w_slast_d = 1'b0;
                        w_state_d = S_IDLE;
                    end else begin
                        // Left shift also zero-fills the short final chunk.
                        w_pk_d    = r_pk_q << CSZ;
                        w_idx_d   = r_idx_q + IDX_W'(1);
                        w_state_d = S_SND_REQ;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge gch_clk) begin
        if (gch_reset) begin
            r_state_q <= S_IDLE;
            r_pk_q    <= '0;
            r_idx_q   <= '0;
            r_ready_q <= 1'b0;
            r_rack_q  <= 1'b0;
            r_sreq_q  <= 1'b0;
            r_sdata_q <= '0;
            r_slast_q <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_pk_q    <= w_pk_d;
            r_idx_q   <= w_idx_d;
            r_ready_q <= w_ready_d;
            r_rack_q  <= w_rack_d;
            r_sreq_q  <= w_sreq_d;
            r_sdata_q <= w_sdata_d;
            r_slast_q <= w_slast_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign gch_ready   = r_ready_q;
    assign rcv0_ack    = r_rack_q;
    assign snd0_req    = r_sreq_q;
    assign snd0_data   = r_sdata_q;
    assign snd0_last   = r_slast_q;
    assign dbg_pkt_cnt = r_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pakout.sv
`default_nettype none
// ============================================================================
// Module   : tb_pakout
// Brief    : Scoreboard bench for pakout: a 32/8 instance and a 20/8 padded one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pakout;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: PSZ=32, CSZ=8
    logic        a_rcv_req = 1'b0;
    logic [31:0] a_rcv_data = '0;
    logic        a_rcv_ack, a_snd_req, a_snd_last, a_ready;
    logic [7:0]  a_snd_data, a_cnt;
    logic        a_snd_ack = 1'b0;

    // Instance B: PSZ=20, CSZ=8 (padded final chunk)
    logic        b_rcv_req = 1'b0;
    logic [19:0] b_rcv_data = '0;
    logic        b_rcv_ack, b_snd_req, b_snd_last, b_ready;
    logic [7:0]  b_snd_data, b_cnt;
    logic        b_snd_ack = 1'b0;

    pakout #(.PSZ(32), .CSZ(8), .CNT_WDH(8)) u_dut_a (
        .gch_clk(clk), .gch_reset(rst), .gch_ready(a_ready),
        .rcv0_req(a_rcv_req), .rcv0_data(a_rcv_data), .rcv0_ack(a_rcv_ack),
        .snd0_req(a_snd_req), .snd0_data(a_snd_data), .snd0_last(a_snd_last),
        .snd0_ack(a_snd_ack), .dbg_pkt_cnt(a_cnt)
    );

    pakout #(.PSZ(20), .CSZ(8), .CNT_WDH(8)) u_dut_b (
        .gch_clk(clk), .gch_reset(rst), .gch_ready(b_ready),
        .rcv0_req(b_rcv_req), .rcv0_data(b_rcv_data), .rcv0_ack(b_rcv_ack),
        .snd0_req(b_snd_req), .snd0_data(b_snd_data), .snd0_last(b_snd_last),
        .snd0_ack(b_snd_ack), .dbg_pkt_cnt(b_cnt)
    );

    // Expected chunks as {last, data}
    logic [8:0] a_q[$];
    logic [8:0] b_q[$];
    logic [8:0] a_cur = '0;
    logic [8:0] b_cur = '0;
    logic       a_prev_req = 1'b0;
    logic       b_prev_req = 1'b0;
    int         a_popped = 0;
    int         a_issued = 0;
    int         b_issued = 0;
    int         a_delay  = 0;
    int         a_wait   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop an expectation on each new chunk, then check it is held.
    always @(negedge clk) begin
        if (rst) begin
            a_prev_req = 1'b0;
        end else begin
            if (a_snd_req && !a_prev_req) begin
                if (a_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL a_unexpected_chunk: got 0x%0h last=%0b, expected none", a_snd_data, a_snd_last);
                end else begin
                    a_cur = a_q.pop_front();
                    check("a_chunk", {55'd0, a_snd_last, a_snd_data}, {55'd0, a_cur});
                    a_popped++;
                end
            end else if (a_snd_req && !a_snd_ack) begin
                check("a_chunk_hold", {55'd0, a_snd_last, a_snd_data}, {55'd0, a_cur});
            end
            a_prev_req = a_snd_req;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_prev_req = 1'b0;
        end else begin
            if (b_snd_req && !b_prev_req) begin
                if (b_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL b_unexpected_chunk: got 0x%0h last=%0b, expected none", b_snd_data, b_snd_last);
                end else begin
                    b_cur = b_q.pop_front();
                    check("b_chunk", {55'd0, b_snd_last, b_snd_data}, {55'd0, b_cur});
                end
            end
            b_prev_req = b_snd_req;
        end
    end

    // Downstream responders (A has a programmable ack delay).
    initial begin
        forever begin
            @(negedge clk);
            if (a_snd_req && !a_snd_ack) begin
                if (a_wait >= a_delay) begin
                    a_snd_ack = 1'b1;
                    a_wait    = 0;
                end else begin
                    a_wait++;
                end
            end else if (!a_snd_req && a_snd_ack) begin
                a_snd_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (b_snd_req && !b_snd_ack)      b_snd_ack = 1'b1;
            else if (!b_snd_req && b_snd_ack) b_snd_ack = 1'b0;
        end
    end

    // Upstream four-phase send on A; pushes the expected chunks first.
    task automatic a_send(input logic [31:0] d);
        int n;
        for (int i = 0; i < 4; i++)
            a_q.push_back({(i == 3), d[31 - 8*i -: 8]});
        a_rcv_data = d;
        a_rcv_req  = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_rcv_ack && n < 2000);
        if (!a_rcv_ack) begin
            n_cmp++; n_err++;
            $display("FAIL a_rcv_ack_timeout: got 0, expected 1");
        end else begin
            // A packet is only accepted once every earlier one has been sent.
            check("a_cnt_at_accept", {56'd0, a_cnt}, {56'd0, 8'(a_issued)});
        end
        a_issued++;
        a_rcv_req = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (a_rcv_ack && n < 100);
        if (a_rcv_ack) begin
            n_cmp++; n_err++;
            $display("FAIL a_rcv_ack_release: got 1, expected 0");
        end
    endtask

    task automatic b_send(input logic [19:0] d);
        int n;
        b_rcv_data = d;
        b_rcv_req  = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!b_rcv_ack && n < 2000);
        if (!b_rcv_ack) begin
            n_cmp++; n_err++;
            $display("FAIL b_rcv_ack_timeout: got 0, expected 1");
        end else begin
            check("b_cnt_at_accept", {56'd0, b_cnt}, {56'd0, 8'(b_issued)});
        end
        b_issued++;
        b_rcv_req = 1'b0;
        do begin @(posedge clk); #1; end while (b_rcv_ack);
    endtask

    task automatic a_drain(input string name, input logic [7:0] exp_cnt);
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end
            while (!(a_q.size() == 0 && !a_snd_req && !a_snd_ack) && n < 20000);
        repeat (2) @(posedge clk);
        #1;
        check(name, {56'd0, a_cnt}, {56'd0, exp_cnt});
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",    {63'd0, a_ready},    64'd0);
        check("rst_rcv_ack",  {63'd0, a_rcv_ack},  64'd0);
        check("rst_snd_req",  {63'd0, a_snd_req},  64'd0);
        check("rst_snd_data", {56'd0, a_snd_data}, 64'd0);
        check("rst_snd_last", {63'd0, a_snd_last}, 64'd0);
        check("rst_cnt",      {56'd0, a_cnt},      64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_1_edge", {63'd0, a_ready}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        check("idle_no_req", {62'd0, a_snd_req, a_rcv_ack}, 64'd0);

        // Basic serialisation, immediate ack
        a_send(32'hA1B2C3D4);
        a_drain("basic_cnt", 8'd1);

        // Padding on instance B: 20'hABCDE -> AB, CD, E0(last)
        b_q.push_back(9'h0AB);
        b_q.push_back(9'h0CD);
        b_q.push_back(9'h1E0);
        b_send(20'hABCDE);
        n = 0;
        do begin @(posedge clk); #1; n++; end
            while (!(b_q.size() == 0 && !b_snd_req && !b_snd_ack) && n < 500);
        repeat (2) @(posedge clk);
        #1;
        check("b_pad_cnt", {56'd0, b_cnt}, 64'd1);

        // Backpressure: second packet pending while the first drains slowly
        a_delay = 7;
        a_send(32'h5566_7788);
        a_send(32'h99AA_BBCC);
        a_drain("backpressure_cnt", 8'd3);
        a_delay = 0;

        // Mid-packet reset after chunk 2 of 4 is acked
        a_popped = 0;
        a_send(32'h1122_3344);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(a_popped == 2 && a_snd_ack) && n < 500);
        rst = 1'b1;
        a_q.delete();
        @(posedge clk); #1;
        check("midrst_snd_req", {63'd0, a_snd_req}, 64'd0);
        check("midrst_rcv_ack", {63'd0, a_rcv_ack}, 64'd0);
        check("midrst_cnt",     {56'd0, a_cnt},     64'd0);
        check("midrst_last",    {63'd0, a_snd_last}, 64'd0);
        rst = 1'b0;
        a_issued = 0;
        @(posedge clk); #1;
        check("midrst_ready", {63'd0, a_ready}, 64'd1);
        a_send(32'h0102_0304);
        a_drain("after_rst_cnt", 8'd1);

        // Counter wrap: 256 packets since reset -> 0, one more -> 1
        for (int i = 1; i < 256; i++)
            a_send(32'hDEAD_BEEF ^ (i * 32'h0101_0101));
        a_drain("wrap_cnt_256", 8'd0);
        a_send(32'hCAFE_F00D);
        a_drain("wrap_cnt_257", 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
